decode_skid_stage: RTL and testbench

//  Multi-lane decode pipeline stage sitting between fetch and issue. Accepts a bundle of

---
 rtl/decode_skid_stage.sv | 163 ++++++++++++++++
 tb/tb_decode_skid_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_skid_stage.sv
// Multi-lane decode stage: classifies branch/jump lanes and registers bundles behind a
// 2-entry skid buffer with registered in_ready. Optional perf counters: DECODE_PERF_CNT_EN.
module decode_skid_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int LANES      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_mask,
  input  logic [ADDR_WIDTH-3:0]   in_addr,
  input  logic [32*LANES-1:0]     in_insn,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_mask,
  output logic [ADDR_WIDTH-3:0]   out_addr,
  output logic [32*LANES-1:0]     out_insn,
  output logic [LANES-1:0]        out_is_branch,
  output logic [LANES-1:0]        out_is_jump
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]             perf_insn_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  typedef struct packed {
    logic [LANES-1:0]      mask;
    logic [ADDR_WIDTH-3:0] addr;
    logic [32*LANES-1:0]   insn;
    logic [LANES-1:0]      is_branch;
    logic [LANES-1:0]      is_jump;
  } bundle_t;

  state_t  r_state;
  logic    r_in_ready;
  logic    r_out_valid;
  bundle_t r_out;
  bundle_t r_skd;

  bundle_t w_new;
  logic    w_in_xfer;
  logic    w_out_xfer;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_new           = '0;
    w_new.mask      = in_mask;
    w_new.addr      = in_addr;
    w_new.insn      = in_insn;
    for (int k = 0; k < LANES; k++) begin
      w_new.is_branch[k] = in_mask[k] && (in_insn[32*k +: 7] == OP_BRANCH);
      w_new.is_jump[k]   = in_mask[k] && ((in_insn[32*k +: 7] == OP_JAL) ||
                                          (in_insn[32*k +: 7] == OP_JALR));
    end
  end

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the data registers are reset as well because the outputs must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_skd       <= '0;
    end else if (flush) begin
      // Flush wins over both handshakes; data registers simply go stale.
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_out       <= w_new;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_out <= w_new;
          end else if (w_in_xfer) begin
            r_skd      <= w_new;
            r_in_ready <= 1'b0;
            r_state    <= S_TWO;
          end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_xfer) begin
            r_out      <= r_skd;
            r_in_ready <= 1'b1;
            r_state    <= S_ONE;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_mask      = r_out.mask;
  assign out_addr      = r_out.addr;
  assign out_insn      = r_out.insn;
  assign out_is_branch = r_out.is_branch;
  assign out_is_jump   = r_out.is_jump;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] r_insn_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] w_lane_cnt;

  always_comb begin
    w_lane_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane_cnt = w_lane_cnt + 32'(r_out.mask[k]);
    end
  end

  // Counters ignore flush and wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_insn_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_out_xfer) begin
        r_insn_cnt <= r_insn_cnt + w_lane_cnt;
      end
      if (r_out_valid && !out_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_insn_cnt  = r_insn_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_decode_skid_stage.sv
// Scoreboard bench for decode_skid_stage: directed bundles with hand-computed classification,
// checked by an independent output monitor. Perf counter checks under DECODE_PERF_CNT_EN.
module tb_decode_skid_stage;

  localparam int AW    = 32;
  localparam int LANES = 2;
  localparam int BW    = LANES + (AW - 2) + 32 * LANES + 2 * LANES;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [LANES-1:0]      in_mask = '0;
  logic [AW-3:0]         in_addr = '0;
  logic [32*LANES-1:0]   in_insn = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [LANES-1:0]      out_mask;
  logic [AW-3:0]         out_addr;
  logic [32*LANES-1:0]   out_insn;
  logic [LANES-1:0]      out_is_branch;
  logic [LANES-1:0]      out_is_jump;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0]           perf_insn_cnt;
  logic [31:0]           perf_stall_cnt;
  logic [31:0]           ins0;
  logic [31:0]           st0;
`endif

  decode_skid_stage #(.ADDR_WIDTH(AW), .LANES(LANES)) dut (
`ifdef DECODE_PERF_CNT_EN
    .perf_insn_cnt (perf_insn_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mask      (in_mask),
    .in_addr      (in_addr),
    .in_insn      (in_insn),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mask     (out_mask),
    .out_addr     (out_addr),
    .out_insn     (out_insn),
    .out_is_branch(out_is_branch),
    .out_is_jump  (out_is_jump)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] exp;
    bit            lat_chk;
    int            acc_cyc;
  } sb_t;

  sb_t sb[$];
  sb_t m_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  waits    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got addr %0h insn %0h, expected no output", out_addr, out_insn);
      end else begin
        m_e = sb.pop_front();
        check("out_bundle", {out_mask, out_addr, out_insn, out_is_branch, out_is_jump}, m_e.exp);
        if (m_e.lat_chk) check("latency", cyc - m_e.acc_cyc, 1);
      end
    end
  end

  task automatic send(input logic [1:0] mask, input logic [29:0] addr, input logic [31:0] l0,
                      input logic [31:0] l1, input logic [1:0] br, input logic [1:0] jmp,
                      input bit lat);
    bit  got = 1'b0;
    sb_t e;
    in_valid = 1'b1;
    in_mask  = mask;
    in_addr  = addr;
    in_insn  = {l1, l0};
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.exp     = {mask, addr, l1, l0, br, jmp};
        e.lat_chk = lat;
        e.acc_cyc = cyc;
        sb.push_back(e);
        got = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accept", got, 1);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", {out_mask, out_addr, out_insn, out_is_branch, out_is_jump}, 0);
    @(posedge clk);
    #1;

    // Streaming at full rate, one-cycle latency, including an all-masked bundle.
    waits = 0;
    send(2'b11, 30'h100, 32'h0000_0013, 32'h00C5_8063, 2'b10, 2'b00, 1);
    send(2'b11, 30'h102, 32'h0080_00EF, 32'h0000_8067, 2'b00, 2'b11, 1);
    send(2'b10, 30'h104, 32'h0000_0063, 32'h0000_0013, 2'b00, 2'b00, 1);
    send(2'b00, 30'h106, 32'h0000_006F, 32'h0000_0063, 2'b00, 2'b00, 1);
    // Classification and masking.
    send(2'b11, 30'h200, 32'h0000_0063, 32'h0000_006F, 2'b01, 2'b10, 1);
    send(2'b01, 30'h202, 32'h0000_0063, 32'h0000_006F, 2'b01, 2'b00, 1);
    check("stream_in_ready_waits", waits, 0);
    wait_drain();

    // Back-pressure: A, B fill both entries, C is held off until the consumer resumes.
    out_ready = 1'b0;
    send(2'b11, 30'h300, 32'h0000_0063, 32'h0000_0013, 2'b01, 2'b00, 0);
    send(2'b11, 30'h302, 32'h0000_006F, 32'h0000_0067, 2'b00, 2'b11, 0);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    waits = 0;
    fork
      send(2'b11, 30'h304, 32'h0000_0033, 32'h0000_1063, 2'b10, 2'b00, 0);
      begin
        repeat (3) @(negedge clk);
        check("bp_hold_in_ready", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_addr", out_addr, 30'h300);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("bp_c_held_off", waits > 0, 1);
    wait_drain();

    // Flush while full with in_valid high: nothing held may emerge.
    out_ready = 1'b0;
    send(2'b11, 30'h400, 32'h0000_0013, 32'h0000_0013, 2'b00, 2'b00, 0);
    send(2'b11, 30'h402, 32'h0000_006F, 32'h0000_0063, 2'b10, 2'b01, 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_mask  = 2'b11;
    in_addr  = 30'h404;
    in_insn  = {32'h0000_0063, 32'h0000_0063};
    @(negedge clk);
    sb.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(2'b11, 30'h406, 32'h0000_0063, 32'h0000_0063, 2'b11, 2'b00, 1);
    wait_drain();

    // Flush while empty: the simultaneous accepted transfer is dropped.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_mask  = 2'b11;
    in_addr  = 30'h408;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_empty_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset while full.
    out_ready = 1'b0;
    send(2'b11, 30'h500, 32'h0000_006F, 32'h0000_006F, 2'b00, 2'b11, 0);
    send(2'b01, 30'h502, 32'h0000_0063, 32'h0000_0063, 2'b01, 2'b00, 0);
    rst = 1'b0;
    @(negedge clk);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_data", {out_mask, out_addr, out_insn, out_is_branch, out_is_jump}, 0);
`ifdef DECODE_PERF_CNT_EN
    check("mid_rst_perf_insn", perf_insn_cnt, 0);
    check("mid_rst_perf_stall", perf_stall_cnt, 0);
`endif
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'b11, 30'h600, 32'h0000_0067, 32'h0000_0013, 2'b00, 2'b01, 1);
    wait_drain();

`ifdef DECODE_PERF_CNT_EN
    // Three bundles of 2+1+1 lanes and exactly four stalled cycles.
    ins0 = perf_insn_cnt;
    st0  = perf_stall_cnt;
    out_ready = 1'b0;
    send(2'b11, 30'h700, 32'h0000_0013, 32'h0000_0013, 2'b00, 2'b00, 0);
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'b01, 30'h702, 32'h0000_0063, 32'h0000_006F, 2'b01, 2'b00, 0);
    send(2'b10, 30'h704, 32'h0000_0063, 32'h0000_006F, 2'b00, 2'b10, 0);
    wait_drain();
    @(negedge clk);
    check("perf_insn_delta", perf_insn_cnt - ins0, 4);
    check("perf_stall_delta", perf_stall_cnt - st0, 4);
`endif

    repeat (5) @(posedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
